// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes and the per-stage
// destination-register record tracked by the forwarding/hazard logic.
package cpu_pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// One producer-vs-source comparator: true when a live writer of a non-zero
// register targets the source register that the consumer actually reads.
module fwd_match #(
    parameter int W = 5
) (
    input  logic         valid,
    input  logic         regwrite,
    input  logic [W-1:0] rd,
    input  logic         used,
    input  logic [W-1:0] src,
    output logic         hit
);

    assign hit = valid && regwrite && (rd != '0) && used && (rd == src);

endmodule

// File: rtl/forward_ctrl_unit.sv
// Forwarding and load-use hazard controller: tracks EX/MEM/WB destination
// metadata, drives the EX operand-mux selects and a one-cycle IF/ID stall.
module forward_ctrl_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    import cpu_pipe_pkg::*;

    slot_t            ex_q, mem_q, wb_q;
    logic [REG_W-1:0] ex_rs_q, ex_rt_q;
    logic             ex_use_rs_q, ex_use_rt_q;

    logic mem_a_hit, wb_a_hit, mem_b_hit, wb_b_hit;
    logic haz_rs_hit, haz_rt_hit;
    logic issue;

    fwd_match #(.W(REG_W)) u_mem_a (
        .valid(mem_q.valid), .regwrite(mem_q.regwrite), .rd(mem_q.rd),
        .used(ex_use_rs_q), .src(ex_rs_q), .hit(mem_a_hit)
    );
    fwd_match #(.W(REG_W)) u_wb_a (
        .valid(wb_q.valid), .regwrite(wb_q.regwrite), .rd(wb_q.rd),
        .used(ex_use_rs_q), .src(ex_rs_q), .hit(wb_a_hit)
    );
    fwd_match #(.W(REG_W)) u_mem_b (
        .valid(mem_q.valid), .regwrite(mem_q.regwrite), .rd(mem_q.rd),
        .used(ex_use_rt_q), .src(ex_rt_q), .hit(mem_b_hit)
    );
    fwd_match #(.W(REG_W)) u_wb_b (
        .valid(wb_q.valid), .regwrite(wb_q.regwrite), .rd(wb_q.rd),
        .used(ex_use_rt_q), .src(ex_rt_q), .hit(wb_b_hit)
    );

    // Hazard check compares the decoding instruction against the load in EX.
    fwd_match #(.W(REG_W)) u_haz_rs (
        .valid(ex_q.valid), .regwrite(ex_q.regwrite), .rd(ex_q.rd),
        .used(id_use_rs), .src(id_rs), .hit(haz_rs_hit)
    );
    fwd_match #(.W(REG_W)) u_haz_rt (
        .valid(ex_q.valid), .regwrite(ex_q.regwrite), .rd(ex_q.rd),
        .used(id_use_rt), .src(id_rt), .hit(haz_rt_hit)
    );

    // MEM is checked first so the youngest in-flight value wins.
    always_comb begin
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (mem_a_hit)     fwd_a_sel = FWD_EXMEM;
        else if (wb_a_hit) fwd_a_sel = FWD_MEMWB;
        if (mem_b_hit)     fwd_b_sel = FWD_EXMEM;
        else if (wb_b_hit) fwd_b_sel = FWD_MEMWB;
    end

    assign stall = id_valid && !flush && ex_q.memread && (haz_rs_hit || haz_rt_hit);
    assign issue = id_valid && !flush && !stall;

    // NOTE: pipeline state uses non-blocking assignments so MEM and WB pick up
    // the pre-edge EX/MEM contents, giving a true shift rather than a fall-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= SLOT_BUBBLE;
            mem_q       <= SLOT_BUBBLE;
            wb_q        <= SLOT_BUBBLE;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_use_rs_q <= 1'b0;
            ex_use_rt_q <= 1'b0;
            stall_count <= '0;
        end else begin
            if (issue) begin
                ex_q        <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                                 memread: id_memread};
                ex_rs_q     <= id_rs;
                ex_rt_q     <= id_rt;
                ex_use_rs_q <= id_use_rs;
                ex_use_rt_q <= id_use_rt;
            end else begin
                ex_q        <= SLOT_BUBBLE;
                ex_rs_q     <= '0;
                ex_rt_q     <= '0;
                ex_use_rs_q <= 1'b0;
                ex_use_rt_q <= 1'b0;
            end
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Scoreboard bench for forward_ctrl_unit: an instruction-history model predicts
// selects/stall per cycle; a negedge monitor pops and compares.
module tb_forward_ctrl_unit;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic             id_use_rs = 1'b0, id_use_rt = 1'b0;
    logic             id_regwrite = 1'b0, id_memread = 1'b0;
    logic             flush = 1'b0;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    forward_ctrl_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rs;
        int rt;
        bit use_rs;
        bit use_rt;
        int rd;
        bit regwrite;
        bit memread;
    } instr_t;

    typedef struct {
        logic [1:0]       a;
        logic [1:0]       b;
        logic             stl;
        logic [CNT_W-1:0] cnt;
        bit               mem_load;
    } exp_t;

    instr_t hist[3];     // instructions now in EX, MEM, WB
    instr_t cur;         // instruction currently presented to ID
    bit     cur_flush;
    int     model_cnt;
    bit     mon_en;
    exp_t   exp_q[$];
    int     n_checks;
    int     n_fail;

    function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt,
                                  int rd, bit rw, bit mr);
        instr_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.use_rs = urs; i.use_rt = urt;
        i.rd = rd; i.regwrite = rw; i.memread = mr;
        return i;
    endfunction

    function automatic bit writes(instr_t p, int r);
        return p.valid && p.regwrite && (p.rd != 0) && (p.rd == r);
    endfunction

    // Nearest older instruction writing the register supplies the operand.
    function automatic logic [1:0] model_sel(bit used, int r);
        if (!hist[0].valid || !used) return 2'b00;
        for (int k = 1; k <= 2; k++)
            if (writes(hist[k], r)) return (k == 1) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit model_stall();
        if (!cur.valid || cur_flush) return 1'b0;
        if (!hist[0].memread) return 1'b0;
        return (cur.use_rs && writes(hist[0], cur.rs)) ||
               (cur.use_rt && writes(hist[0], cur.rt));
    endfunction

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) hist[k] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        model_cnt = 0;
    endtask

    task automatic model_advance();
        bit s;
        s = model_stall();
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (cur.valid && !cur_flush && !s) ? cur : mk(0, 0, 0, 0, 0, 0, 0, 0);
        if (s && model_cnt < (1 << CNT_W) - 1) model_cnt++;
    endtask

    task automatic drive(instr_t i, bit f);
        cur = i; cur_flush = f;
        id_valid = i.valid; id_rs = REG_W'(i.rs); id_rt = REG_W'(i.rt);
        id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_rd = REG_W'(i.rd);
        id_regwrite = i.regwrite; id_memread = i.memread; flush = f;
    endtask

    task automatic push_expected();
        exp_t e;
        e.a = model_sel(hist[0].use_rs, hist[0].rs);
        e.b = model_sel(hist[0].use_rt, hist[0].rt);
        e.stl = model_stall();
        e.cnt = CNT_W'(model_cnt);
        e.mem_load = hist[1].valid && hist[1].memread;
        exp_q.push_back(e);
    endtask

    // One ID cycle: clock edge, model step, present new instruction, predict.
    task automatic issue(instr_t i, bit f);
        @(posedge clk);
        model_advance();
        #1;
        drive(i, f);
        push_expected();
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fwd_a_sel", 32'(fwd_a_sel), 32'(e.a));
            check("fwd_b_sel", 32'(fwd_b_sel), 32'(e.b));
            check("stall", 32'(stall), 32'(e.stl));
            check("stall_count", 32'(stall_count), 32'(e.cnt));
            if (e.mem_load)
                check("no_load_fwd_from_mem",
                      32'((fwd_a_sel == 2'b01) || (fwd_b_sel == 2'b01)), 32'd0);
        end
    end

    instr_t idle, load7, use7, ri, nxt;
    bit     fl;

    initial begin
        n_checks = 0; n_fail = 0; mon_en = 1'b0;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        drive(idle, 1'b0);

        #12;
        check("reset_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("reset_fwd_b", 32'(fwd_b_sel), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Load-use: one stall, bubble, then WB forwarding on rt.
        load7 = mk(1, 0, 0, 0, 0, 7, 1, 1);
        use7  = mk(1, 1, 7, 0, 1, 8, 1, 0);
        issue(load7, 0);
        issue(use7, 0);
        check("lu_stall_on", 32'(stall), 32'd1);
        issue(use7, 0);
        check("lu_stall_once", 32'(stall), 32'd0);
        check("lu_count", 32'(stall_count), 32'd1);
        issue(idle, 0);
        check("lu_fwd_b_wb", 32'(fwd_b_sel), 32'd2);

        // ALU dependency: MEM forward on A, then WB forward on B.
        issue(mk(1, 0, 0, 0, 0, 3, 1, 0), 0);
        issue(mk(1, 3, 0, 1, 0, 9, 1, 0), 0);
        issue(mk(1, 0, 3, 0, 1, 10, 1, 0), 0);
        check("alu_fwd_a_mem", 32'(fwd_a_sel), 32'd1);
        issue(idle, 0);
        check("alu_fwd_b_wb", 32'(fwd_b_sel), 32'd2);

        // Double match: MEM wins over WB.
        issue(mk(1, 0, 0, 0, 0, 5, 1, 0), 0);
        issue(mk(1, 0, 0, 0, 0, 5, 1, 0), 0);
        issue(mk(1, 5, 0, 1, 0, 11, 1, 0), 0);
        issue(idle, 0);
        check("dbl_fwd_a_mem", 32'(fwd_a_sel), 32'd1);

        // Register zero: never forwarded, never stalled on.
        issue(mk(1, 0, 0, 0, 0, 0, 1, 0), 0);
        issue(mk(1, 0, 0, 1, 0, 12, 1, 0), 0);
        issue(idle, 0);
        check("r0_fwd_a", 32'(fwd_a_sel), 32'd0);
        issue(mk(1, 0, 0, 0, 0, 0, 1, 1), 0);
        issue(mk(1, 0, 0, 1, 1, 13, 1, 0), 0);
        check("r0_no_stall", 32'(stall), 32'd0);

        // Flush beats hazard.
        issue(mk(1, 0, 0, 0, 0, 4, 1, 1), 0);
        issue(mk(1, 4, 0, 1, 0, 14, 1, 0), 1);
        check("flush_no_stall", 32'(stall), 32'd0);
        issue(idle, 0);
        check("flush_count_kept", 32'(stall_count), 32'd1);

        // Asynchronous reset in the middle of a stall.
        issue(load7, 0);
        issue(use7, 0);
        check("mid_stall_on", 32'(stall), 32'd1);
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_fwd_a", 32'(fwd_a_sel), 32'd0);
        check("arst_fwd_b", 32'(fwd_b_sel), 32'd0);
        check("arst_count", 32'(stall_count), 32'd0);
        drive(idle, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        issue(mk(1, 4, 0, 1, 0, 15, 1, 0), 0);
        issue(idle, 0);
        check("post_rst_fwd_a", 32'(fwd_a_sel), 32'd0);

        // Random traffic; a stalled ID instruction is re-presented, as decode would.
        ri = idle;
        for (int n = 0; n < 3000; n++) begin
            if (stall && !flush) begin
                nxt = ri;
            end else begin
                nxt = mk(($urandom_range(0, 9) != 0), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                         $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                         $urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 11) == 0);
            ri = nxt;
            issue(nxt, fl);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
